// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - highway/farm-road intersection sequencer
module traffic_light_controller #(
  parameter int DEBOUNCE       = 3,
  parameter int HWY_GREEN_MIN  = 8,
  parameter int YELLOW_TIME    = 3,
  parameter int ALLRED_TIME    = 1,
  parameter int FARM_GREEN_MIN = 2,
  parameter int FARM_GREEN_MAX = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       car_sensor,
  input  logic       ped_req,
  output logic [2:0] hwy_light,
  output logic [2:0] farm_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    HWY_G  = 3'd0,
    HWY_Y  = 3'd1,
    RED_A  = 3'd2,
    FARM_G = 3'd3,
    FARM_Y = 3'd4,
    RED_B  = 3'd5
  } state_t;

  // Timer compare points: the phase exits on the tick that completes its Nth count.
  localparam logic [3:0] DEB_THR   = 4'(DEBOUNCE);
  localparam logic [7:0] HMIN_LAST = 8'(HWY_GREEN_MIN - 1);
  localparam logic [7:0] YEL_LAST  = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] AR_LAST   = 8'(ALLRED_TIME - 1);
  localparam logic [7:0] FMIN_LAST = 8'(FARM_GREEN_MIN - 1);
  localparam logic [7:0] FMAX_LAST = 8'(FARM_GREEN_MAX - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] tmr;
  logic [3:0] qcnt;
  logic       car_q;
  logic       ped_pend;
  logic       walk_r;
  logic       enter_farm;
  logic       exit_farm;

  assign car_q      = (qcnt >= DEB_THR);
  assign enter_farm = (state_next == FARM_G) && (state != FARM_G);
  assign exit_farm  = (state == FARM_G) && (state_next != FARM_G);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= HWY_G;
    else        state <= state_next;
  end

  // Next-state logic; every phase advance is gated by the timebase tick.
  always_comb begin
    state_next = state;
    case (state)
      HWY_G:  if (tick && (tmr >= HMIN_LAST) && (car_q || ped_pend)) state_next = HWY_Y;
      HWY_Y:  if (tick && (tmr == YEL_LAST)) state_next = RED_A;
      RED_A:  if (tick && (tmr == AR_LAST))  state_next = FARM_G;
      FARM_G: if (tick && ((tmr == FMAX_LAST) ||
                           ((tmr >= FMIN_LAST) && !car_q && !walk_r))) state_next = FARM_Y;
      FARM_Y: if (tick && (tmr == YEL_LAST)) state_next = RED_B;
      RED_B:  if (tick && (tmr == AR_LAST))  state_next = HWY_G;
      default: state_next = HWY_G;
    endcase
  end

  // Phase timer: restarts on every state change, counts ticks, saturates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      tmr <= 8'd0;
    else if (state_next != state)    tmr <= 8'd0;
    else if (tick && tmr != 8'hFF)   tmr <= tmr + 8'd1;
  end

  // Car qualifier: counts consecutive high samples, any low sample restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)               qcnt <= 4'd0;
    else if (!car_sensor)     qcnt <= 4'd0;
    else if (qcnt != 4'hF)    qcnt <= qcnt + 4'd1;
  end

  // Pedestrian latch: a new request outranks the clear on farm-green entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          ped_pend <= 1'b0;
    else if (ped_req)    ped_pend <= 1'b1;
    else if (enter_farm) ped_pend <= 1'b0;
  end

  // Walk is granted for a whole farm green only if it was pending at entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          walk_r <= 1'b0;
    else if (enter_farm) walk_r <= ped_pend;
    else if (exit_farm)  walk_r <= 1'b0;
  end

  // Moore light decode straight from the state register.
  always_comb begin
    hwy_light  = 3'b100;
    farm_light = 3'b100;
    case (state)
      HWY_G:   hwy_light  = 3'b001;
      HWY_Y:   hwy_light  = 3'b010;
      FARM_G:  farm_light = 3'b001;
      FARM_Y:  farm_light = 3'b010;
      default: begin
        hwy_light  = 3'b100;
        farm_light = 3'b100;
      end
    endcase
  end

  assign walk  = walk_r;
  assign phase = state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - randomized and directed checks against a tick-count model
module tb_traffic_light_controller;

  localparam int DEB  = 3;
  localparam int HMIN = 4;
  localparam int YEL  = 2;
  localparam int AR   = 1;
  localparam int FMIN = 2;
  localparam int FMAX = 5;

  localparam logic [2:0] HWY_TAB  [0:5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  localparam logic [2:0] FARM_TAB [0:5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  localparam int SEQ [0:15] = '{0,0,0,0,1,1,2,3,3,3,3,3,4,4,5,0};

  logic       clock;
  logic       reset;
  logic       tick;
  logic       car_sensor;
  logic       ped_req;
  logic [2:0] hwy_light;
  logic [2:0] farm_light;
  logic       walk;
  logic [2:0] phase;

  int total;
  int bad;

  // Reference model: phase index, ticks spent in phase, consecutive sensor-high run.
  int m_phase;
  int m_ticks;
  int m_run;
  bit m_ped;
  bit m_walk;

  traffic_light_controller #(
    .DEBOUNCE(DEB), .HWY_GREEN_MIN(HMIN), .YELLOW_TIME(YEL),
    .ALLRED_TIME(AR), .FARM_GREEN_MIN(FMIN), .FARM_GREEN_MAX(FMAX)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .car_sensor(car_sensor),
    .ped_req(ped_req), .hwy_light(hwy_light), .farm_light(farm_light),
    .walk(walk), .phase(phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_clear();
    m_phase = 0; m_ticks = 0; m_run = 0; m_ped = 0; m_walk = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  el;
    int  nxt;
    bit  car_ok;
    bit  go;
    car_ok = (m_run >= DEB);
    go = 0;
    el = m_ticks + 1;
    if (tick) begin
      case (m_phase)
        0:       go = (el >= HMIN) && (car_ok || m_ped);
        1, 4:    go = (el == YEL);
        2, 5:    go = (el == AR);
        3:       go = (el == FMAX) || ((el >= FMIN) && !car_ok && !m_walk);
        default: go = 0;
      endcase
    end
    nxt = go ? (m_phase + 1) % 6 : m_phase;
    if (nxt == 3 && m_phase != 3)      m_walk = m_ped;
    else if (m_phase == 3 && nxt != 3) m_walk = 0;
    if (ped_req)                       m_ped = 1;
    else if (nxt == 3 && m_phase != 3) m_ped = 0;
    if (go)                            m_ticks = 0;
    else if (tick && m_ticks < 255)    m_ticks = m_ticks + 1;
    m_run = car_sensor ? ((m_run < 15) ? m_run + 1 : 15) : 0;
    m_phase = nxt;
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; tick = 1'b1; car_sensor = 1'b0; ped_req = 1'b0;
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    reset = 1'b0; tick = 1'b1; car_sensor = 1'b1; ped_req = 1'b1;
    model_clear();
    repeat (2) @(negedge clock);
    got = {hwy_light, farm_light, walk, phase};
    total++;
    if (got !== 10'b001_100_0_000) begin
      bad++; $display("FAIL reset_hold got=%b want=%b", got, 10'b001_100_0_000);
    end
    car_sensor = 1'b0; ped_req = 1'b0;
    reset = 1'b1;
    step();
    got = {hwy_light, farm_light, walk, phase};
    total++;
    if (got !== 10'b001_100_0_000) begin
      bad++; $display("FAIL reset_release got=%b want=%b", got, 10'b001_100_0_000);
    end
  endtask

  task automatic test_idle();
    logic [9:0] got;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      got = {hwy_light, farm_light, walk, phase};
      total++;
      if (got !== 10'b001_100_0_000) begin
        bad++; $display("FAIL idle cyc=%0d got=%b want=%b", i, got, 10'b001_100_0_000);
      end
      step();
    end
  endtask

  task automatic test_short_pulse();
    do_reset();
    car_sensor = 1'b1;
    for (int i = 0; i < 30; i++) begin
      total++;
      if (phase !== 3'd0) begin
        bad++; $display("FAIL short_pulse cyc=%0d phase=%0d want=0", i, phase);
      end
      step();
      if (i == 1) car_sensor = 1'b0;
    end
  endtask

  task automatic test_car_held();
    logic [9:0] got;
    logic [9:0] exp;
    do_reset();
    car_sensor = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (phase !== 3'(SEQ[i])) begin
        bad++; $display("FAIL car_held_seq cyc=%0d phase=%0d want=%0d", i, phase, SEQ[i]);
      end
      got = {hwy_light, farm_light, walk, phase};
      exp = {HWY_TAB[m_phase], FARM_TAB[m_phase], m_walk, 3'(m_phase)};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL car_held_model cyc=%0d got=%b want=%b", i, got, exp);
      end
      step();
    end
    car_sensor = 1'b0;
  endtask

  task automatic test_ped();
    int   ep;
    logic ew;
    do_reset();
    ped_req = 1'b1;
    for (int i = 0; i < 26; i++) begin
      ep = (i < 16) ? SEQ[i] : 0;
      ew = (i >= 7 && i <= 11);
      total++;
      if ({phase, walk} !== {3'(ep), ew}) begin
        bad++; $display("FAIL ped cyc=%0d phase=%0d walk=%0d want phase=%0d walk=%0d",
                        i, phase, walk, ep, ew);
      end
      step();
      ped_req = 1'b0;
    end
  endtask

  task automatic test_car_removed();
    logic [2:0] ef;
    do_reset();
    car_sensor = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ef = (i == 7 || i == 8) ? 3'b001 : (i == 9 || i == 10) ? 3'b010 : 3'b100;
      total++;
      if (farm_light !== ef) begin
        bad++; $display("FAIL car_removed cyc=%0d farm=%b want=%b", i, farm_light, ef);
      end
      step();
      if (i == 3) car_sensor = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    int         cnt;
    do_reset();
    car_sensor = 1'b1;
    repeat (12) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    car_sensor = 1'b0;
    total++;
    if (phase !== 3'd4) begin
      bad++; $display("FAIL reset_mid_pre phase=%0d want=4", phase);
    end
    #2 reset = 1'b0;
    model_clear();
    #1;
    got = {hwy_light, farm_light, walk, phase};
    total++;
    if (got !== 10'b001_100_0_000) begin
      bad++; $display("FAIL reset_mid_async got=%b want=%b", got, 10'b001_100_0_000);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (phase !== 3'd0) begin
        bad++; $display("FAIL reset_mid_pedclr cyc=%0d phase=%0d want=0", i, phase);
      end
      step();
    end
    do_reset();
    ped_req = 1'b1;
    cnt = 0;
    while (phase == 3'd0 && cnt < 20) begin
      cnt++;
      step();
      ped_req = 1'b0;
    end
    total++;
    if (cnt != HMIN) begin
      bad++; $display("FAIL reset_mid_mingreen cycles=%0d want=%0d", cnt, HMIN);
    end
  endtask

  task automatic test_random();
    logic [9:0] got;
    logic [9:0] exp;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      got = {hwy_light, farm_light, walk, phase};
      exp = {HWY_TAB[m_phase], FARM_TAB[m_phase], m_walk, 3'(m_phase)};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, got, exp);
      end
      total++;
      if (hwy_light[0] && farm_light[0]) begin
        bad++; $display("FAIL random_dual_green cyc=%0d hwy=%b farm=%b want no dual green",
                        i, hwy_light, farm_light);
      end
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        tick = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 6) == 0) car_sensor = ~car_sensor;
        ped_req = ($urandom_range(0, 29) == 0);
        step();
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; tick = 1'b1; car_sensor = 1'b0; ped_req = 1'b0;
    model_clear();
    test_reset();
    test_idle();
    test_short_pulse();
    test_car_held();
    test_ped();
    test_car_removed();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
